uart_dma_ctrl: RTL
==================

Name: uart_dma_ctrl

Overview:
Autonomous DMA-style sequencer that drives the UART core's native register port (reg_addr/reg_wdata/reg_we/reg_re/reg_be/reg_rdata) from the core's dma_tx_req/dma_rx_req handshake.
- Moves bytes from an AXI-Stream-style TX input into the core TX data register.
- Moves bytes from the core RX data register to an AXI-Stream-style RX output.
- Round-robin arbitration between the two directions over the single register port.
- Instantiated beside the UART core in place of the host register path when the system runs in streaming mode.

Parameters:
TXDATA_ADDR, 32'h0000_0000, core TX data register address
RXDATA_ADDR, 32'h0000_0004, core RX data register address
RD_LATENCY, 1, cycles from reg_re high to valid reg_rdata (range 1..4)
HOLDOFF, 2, cycles a direction is ineligible after being serviced, covering req-deassert lag in the core (range 0..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  allow new transfers
dma_tx_req  in  1  core can accept a TX byte
dma_rx_req  in  1  core holds an RX byte
tx_tdata  in  8  TX byte
tx_tvalid  in  1  TX byte valid
tx_tready  out  1  TX byte consumed
rx_tdata  out  8  RX byte
rx_tvalid  out  1  RX byte valid
rx_tready  in  1  RX sink ready
reg_addr  out  32  core register address
reg_wdata  out  32  core write data
reg_be  out  4  byte enables
reg_we  out  1  write strobe
reg_re  out  1  read strobe
reg_rdata  in  32  core read data
busy  out  1  state != IDLE
tx_count  out  16  bytes written to core
rx_count  out  16  bytes delivered to sink

Behaviour:
Clock and reset:
- Single clock domain, clk.
- rst_n asynchronous assert, synchronous deassert handled externally.
- On reset, all outputs are 0; state=IDLE, holdoff counters=0, RR pointer favours RX.
- Reset mid-transfer aborts the transfer; any captured RX byte is discarded.

Outputs:
- All outputs are registered.
- reg_we/reg_re are single-cycle pulses and are never high together.

States:
- IDLE, TX_WR, RD_ISSUE, RD_WAIT.

Eligibility and arbitration (evaluated in IDLE):
- tx_elig = enable & dma_tx_req & tx_tvalid & (tx_hold==0).
- rx_elig = enable & dma_rx_req & ~rx_tvalid & (rx_hold==0).
- Both eligible: grant the direction not granted last, then toggle the RR pointer.
- One eligible: grant it. No arbitration outside IDLE.

TX path:
- IDLE -> TX_WR (cycle N+1 after eligibility at cycle N).
- In TX_WR: reg_we=1, reg_addr=TXDATA_ADDR, reg_wdata={24'h0,tx_tdata}, reg_be=4'b0001, tx_tready=1 (same cycle).
- tx_hold loaded with HOLDOFF; tx_count++; next state IDLE.

RX path:
- IDLE -> RD_ISSUE: reg_re=1, reg_addr=RXDATA_ADDR, reg_be=4'hF.
- RD_WAIT: count RD_LATENCY cycles, then capture reg_rdata[7:0] into rx_tdata and set rx_tvalid.
- rx_hold loaded with HOLDOFF; next state IDLE.
- rx_tvalid/rx_tdata hold until rx_tready; on that handshake, rx_tvalid clears and rx_count++.
- No further RX read while rx_tvalid=1; this is the backpressure path.

Holdoff counters:
- Decrement to 0 every cycle, independently per direction.
- HOLDOFF=0 allows back-to-back service of the same direction with 1 idle cycle.

Other rules:
- enable dropped mid-transfer: the current transfer completes; no new grants.
- Counters wrap 16'hFFFF -> 0.
- dma_*_req changes outside IDLE are ignored.
- Minimum TX throughput: 1 byte per 2+HOLDOFF cycles when TX alone is active.

Optional Feature:
UART_DMA_CTRL_STATS_EN
- Defined: tx_count/rx_count implemented as described.
- Undefined: both ports tied to 16'h0 and the counter logic is removed; all other behaviour is identical.

Test Plan:
1. TX single: tx_tdata=8'hA5, tx_tvalid=1, dma_tx_req=1 -> one cycle later reg_we=1, reg_addr=0x0, reg_wdata=0x000000A5, reg_be=4'b0001, tx_tready=1; tx_count=1.
2. RX single (RD_LATENCY=1): dma_rx_req=1, core returns 0x0000003C -> reg_re pulse at addr 0x4; rx_tvalid=1 with rx_tdata=8'h3C; hold 5 cycles while rx_tready=0, then pop; rx_count=1.
3. RX backpressure: rx_tready=0, dma_rx_req held 1 -> exactly one reg_re issued until the sink pops, then the next read is issued after holdoff expires.
4. Contention: both reqs and tx_tvalid held high for 8 grants -> grant order RX,TX,RX,TX...; no cycle has reg_we & reg_re.
5. Holdoff (HOLDOFF=2): dma_tx_req stuck high, 3 bytes queued -> reg_we pulses spaced 4 cycles apart.
6. Reset in RD_WAIT: rst_n low -> all outputs 0 immediately, busy=0, no rx_tvalid after release.

Source files
------------

// File: rtl/uart_dma_ctrl.sv
// uart_dma_ctrl: DMA-style sequencer between AXI-Stream TX/RX ports and the UART core register port.
// Optional macro UART_DMA_CTRL_STATS_EN implements tx_count/rx_count; otherwise both are tied to zero.

module uart_dma_ctrl #(
  parameter logic [31:0] TXDATA_ADDR = 32'h0000_0000,
  parameter logic [31:0] RXDATA_ADDR = 32'h0000_0004,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned HOLDOFF     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        dma_tx_req,
  input  logic        dma_rx_req,
  input  logic [7:0]  tx_tdata,
  input  logic        tx_tvalid,
  output logic        tx_tready,
  output logic [7:0]  rx_tdata,
  output logic        rx_tvalid,
  input  logic        rx_tready,
  output logic [31:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [31:0] reg_rdata,
  output logic        busy,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_TX_WR    = 2'd1;
  localparam logic [1:0] S_RD_ISSUE = 2'd2;
  localparam logic [1:0] S_RD_WAIT  = 2'd3;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF);
  localparam logic [1:0] LAT_LOAD  = 2'(RD_LATENCY - 1);

  logic [1:0] state;
  logic [3:0] tx_hold;
  logic [3:0] rx_hold;
  logic [1:0] lat_cnt;
  logic       rr_rx;
  logic       tx_elig;
  logic       rx_elig;
  logic       grant_tx;
  logic       grant_rx;
  logic       unused_rdata;

  assign unused_rdata = ^reg_rdata[31:8];

  always_comb begin
    tx_elig  = enable & dma_tx_req & tx_tvalid & (tx_hold == '0);
    rx_elig  = enable & dma_rx_req & ~rx_tvalid & (rx_hold == '0);
    grant_tx = 1'b0;
    grant_rx = 1'b0;
    if (state == S_IDLE) begin
      if (tx_elig && rx_elig) begin
        grant_rx = rr_rx;
        grant_tx = ~rr_rx;
      end else begin
        grant_tx = tx_elig;
        grant_rx = rx_elig;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tx_hold   <= '0;
      rx_hold   <= '0;
      lat_cnt   <= '0;
      rr_rx     <= 1'b1;
      busy      <= 1'b0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_be    <= '0;
      tx_tready <= 1'b0;
      rx_tvalid <= 1'b0;
      rx_tdata  <= '0;
    end else begin
      // Strobes and bus fields are single-cycle; only the granting branch re-asserts them.
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      tx_tready <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_be    <= '0;
      if (tx_hold != '0) tx_hold <= tx_hold - 4'd1;
      if (rx_hold != '0) rx_hold <= rx_hold - 4'd1;
      if (rx_tvalid && rx_tready) rx_tvalid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (tx_elig && rx_elig) rr_rx <= ~rr_rx;
          if (grant_tx) begin
            state     <= S_TX_WR;
            busy      <= 1'b1;
            reg_we    <= 1'b1;
            reg_addr  <= TXDATA_ADDR;
            reg_wdata <= {24'h0, tx_tdata};
            reg_be    <= 4'b0001;
            tx_tready <= 1'b1;
          end else if (grant_rx) begin
            state    <= S_RD_ISSUE;
            busy     <= 1'b1;
            reg_re   <= 1'b1;
            reg_addr <= RXDATA_ADDR;
            reg_be   <= 4'hF;
          end
        end
        S_TX_WR: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          tx_hold <= HOLD_LOAD;
        end
        S_RD_ISSUE: begin
          state   <= S_RD_WAIT;
          lat_cnt <= LAT_LOAD;
        end
        S_RD_WAIT: begin
          if (lat_cnt == '0) begin
            rx_tdata  <= reg_rdata[7:0];
            rx_tvalid <= 1'b1;
            rx_hold   <= HOLD_LOAD;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_DMA_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      if (state == S_TX_WR) tx_count <= tx_count + 16'd1;
      if (rx_tvalid && rx_tready) rx_count <= rx_count + 16'd1;
    end
  end
`else
  assign tx_count = '0;
  assign rx_count = '0;
`endif

endmodule
